div_ctrl: RTL
=============

Name: div_ctrl

Overview:
- Multi-cycle radix-2 restoring divider with a sequencing FSM.
- Serves the EX stage for DIV/DIVU: EX raises a request and holds its operands, the block stalls the pipeline until the quotient and remainder are ready.
- Owns the only iterative divider; it is not pipelined, so one operation is in flight at a time.
- Results go back to EX for the HI/LO write.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_start  in  1  divide request from EX; held high until o_ready is seen.
- i_signed  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- i_dividend  in  WIDTH  dividend, sampled at accept.
- i_divisor  in  WIDTH  divisor, sampled at accept.
- i_annul  in  1  abort the current or pending request (flush or exception).
- o_busy  out  1  FSM is not in IDLE.
- o_stallreq  out  1  combinational stall request to the pipeline controller.
- o_ready  out  1  result valid.
- o_result  out  2*WIDTH  {remainder, quotient}.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, cnt=0, o_ready=0, o_result=0, internal dividend/remainder registers cleared. rst overrides every other input, including in the middle of an operation.
- States: IDLE, DIVZERO, ON, END. Encoding is a 2-bit registered state.
- IDLE:
  - If i_start=1 and i_annul=0 at the edge, the request is accepted and operands are latched.
  - If the divisor is 0, go to DIVZERO; otherwise go to ON with cnt=0.
  - If i_annul=1, stay in IDLE (annul wins over start).
- ON:
  - One quotient bit per cycle: shift {rem, dvd} left 1; trial subtract the divisor; if the result is non-negative, keep it and set quotient bit 1.
  - cnt increments each cycle; after the WIDTH-th iteration (cnt==WIDTH-1), go to END and load o_result.
  - i_annul=1 goes to IDLE immediately; o_ready never asserts and o_result is left unchanged.
  - i_start and operand changes are ignored while in ON.
- DIVZERO: next edge goes to END with o_result=0.
- END:
  - o_ready=1 and o_result is held stable.
  - Stay in END while i_start=1. When i_start=0, go to IDLE and clear o_ready on that edge.
  - i_annul in END goes to IDLE.
- Latency, with the request accepted at edge 0:
  - Normal divide: o_ready visible after edge WIDTH+1 (33 for WIDTH=32).
  - Divide by zero: o_ready visible after edge 2.
- o_stallreq = i_start & ~o_ready & ~i_annul. Stall drops in the same cycle o_ready rises.
- o_busy = (state != IDLE).
- Back-to-back requests: a new request is accepted only from IDLE, so at least one idle cycle separates operations.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - When i_signed=1, operands are converted to magnitudes at accept, and the signs are recorded.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Sign fix-up happens on the transition into END, so latency is unchanged.
  - Most-negative / -1 yields quotient 0x80000000, remainder 0.
- Undefined: i_signed is ignored and all operations are unsigned. The port is still present so the EX interface does not change.

Decomposition:
- Shared package (cpu_defs_pkg) holds:
  - div FSM state encodings: DIV_IDLE, DIV_DIVZERO, DIV_ON, DIV_END.
  - aluop constants for DIV and DIVU.
  - WIDTH default.
- One natural sub-module: div_step. It is combinational and produces one restoring iteration: next {rem, dvd} and the quotient bit from the current {rem, dvd} and the divisor.
- FSM, counter and sign handling stay in div_ctrl.

Test Plan:
- Unsigned divide: start, signed=0, 100/7 -> o_ready after edge 33, o_result={32'd2, 32'd14}; o_stallreq high through edge 32, low when ready.
- Divide by zero: 0x1234/0 -> o_ready after edge 2, o_result=0; drop i_start -> IDLE and o_ready=0 on the next edge.
- Signed divide (DIV_SIGNED_EN): -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
- Annul: assert i_annul at cycle 10 of ON -> IDLE on the next edge, no o_ready pulse. A following 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF} at the normal latency.
- Reset mid-operation: rst=1 at cycle 20 -> state IDLE, o_ready=0, o_result=0 on that edge. A start with i_annul=1 in IDLE -> not accepted, o_busy stays 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions used by the divider slice: divider FSM state
// encodings, the ALU opcodes that route to the divider and the default
// datapath width.
package cpu_defs_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
   localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

   typedef enum logic [1:0] {
      DIV_IDLE    = 2'b00,
      DIV_DIVZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// EX <-> divider handshake. EX drives the request side (master), the
// divider returns busy/stall/ready/result (slave).
interface div_ctrl_if
   import cpu_defs_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);
   logic               i_start;
   logic               i_signed;
   logic [WIDTH-1:0]   i_dividend;
   logic [WIDTH-1:0]   i_divisor;
   logic               i_annul;
   logic               o_busy;
   logic               o_stallreq;
   logic               o_ready;
   logic [2*WIDTH-1:0] o_result;

   modport master (
      output i_start, i_signed, i_dividend, i_divisor, i_annul,
      input  o_busy, o_stallreq, o_ready, o_result
   );

   modport slave (
      input  i_start, i_signed, i_dividend, i_divisor, i_annul,
      output o_busy, o_stallreq, o_ready, o_result
   );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, dvd} left by one, trial
// subtract the divisor from the upper half and keep it when non-negative.
// The quotient bit is shifted into the bottom of dvd, so after WIDTH steps
// dvd holds the quotient and rem the remainder.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_dvd,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_dvd,
   output logic             o_qbit
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // Trial subtraction on a WIDTH+1 wide partial remainder; MSB is the borrow.
   always_comb begin
      shifted = {i_rem, i_dvd[WIDTH-1]};
      trial   = shifted - {1'b0, i_divisor};
      o_qbit  = ~trial[WIDTH];
      o_rem   = o_qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      o_dvd   = {i_dvd[WIDTH-2:0], o_qbit};
   end
endmodule

// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
// Optional signed support is enabled by defining DIV_SIGNED_EN; without it
// i_signed is ignored and every operation is unsigned.
//
// state       | meaning
// ------------+------------------------------------------------------
// DIV_IDLE    | waiting for an un-annulled request
// DIV_DIVZERO | divisor was zero, result forced to 0 next edge
// DIV_ON      | one quotient bit per cycle, WIDTH cycles
// DIV_END     | result loaded; o_ready held until EX drops i_start
module div_ctrl
   import cpu_defs_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic       clk,
   input  logic       rst,
   div_ctrl_if.slave  bus
);
   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dsr_q, dsr_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic               ready_q, ready_d;
   logic [2*WIDTH-1:0] result_q, result_d;

   logic [WIDTH-1:0]   step_rem, step_dvd;
   logic               step_qbit;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               a_neg, b_neg;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (rem_q),
      .i_dvd     (dvd_q),
      .i_divisor (dsr_q),
      .o_rem     (step_rem),
      .o_dvd     (step_dvd),
      .o_qbit    (step_qbit)
   );

`ifdef DIV_SIGNED_EN
   // Signed operands are reduced to magnitudes at accept; the most-negative
   // value maps to itself, which is the correct unsigned magnitude.
   always_comb begin
      a_neg = bus.i_signed & bus.i_dividend[WIDTH-1];
      b_neg = bus.i_signed & bus.i_divisor[WIDTH-1];
      a_mag = a_neg ? (~bus.i_dividend + 1'b1) : bus.i_dividend;
      b_mag = b_neg ? (~bus.i_divisor  + 1'b1) : bus.i_divisor;
   end
`else
   logic unused_signed;
   assign unused_signed = bus.i_signed ^ step_qbit;

   // Unsigned-only build: operands pass straight through.
   always_comb begin
      a_neg = 1'b0;
      b_neg = 1'b0;
      a_mag = bus.i_dividend;
      b_mag = bus.i_divisor;
   end
`endif

   // Next-state, datapath and result loading.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dsr_d     = dsr_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      ready_d   = 1'b0;
      result_d  = result_q;

      unique case (state_q)
         DIV_IDLE: begin
            if (bus.i_start && !bus.i_annul) begin
               rem_d     = '0;
               dvd_d     = a_mag;
               dsr_d     = b_mag;
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               cnt_d     = '0;
               state_d   = (bus.i_divisor == '0) ? DIV_DIVZERO : DIV_ON;
            end
         end
         DIV_DIVZERO: begin
            if (bus.i_annul) begin
               state_d = DIV_IDLE;
            end else begin
               result_d = '0;
               state_d  = DIV_END;
            end
         end
         DIV_ON: begin
            if (bus.i_annul) begin
               state_d = DIV_IDLE;
            end else begin
               rem_d = step_rem;
               dvd_d = step_dvd;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  // Sign fix-up folded into the load so latency is unchanged.
                  result_d = {neg_rem_q ? (~step_rem + 1'b1) : step_rem,
                              neg_quo_q ? (~step_dvd + 1'b1) : step_dvd};
                  cnt_d    = '0;
                  state_d  = DIV_END;
               end
            end
         end
         DIV_END: begin
            if (bus.i_annul || !bus.i_start) begin
               state_d = DIV_IDLE;
            end else begin
               ready_d = 1'b1;
            end
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DIV_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ready_q   <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dsr_q     <= dsr_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         ready_q   <= ready_d;
         result_q  <= result_d;
      end
   end

   assign bus.o_ready    = ready_q;
   assign bus.o_result   = result_q;
   assign bus.o_busy     = (state_q != DIV_IDLE);
   assign bus.o_stallreq = bus.i_start & ~ready_q & ~bus.i_annul;
endmodule
